// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe -- pipelined floating-point multiplier, round-to-nearest-even.
//
// Word layout {sign, exponent, fraction}, exponent bias 2^(EXP_W-1)-1.
// Denormal operands are treated as signed zero; underflowing results are
// flushed to signed zero.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous reset, active low
//   in_valid   operand pair presented
//   in_ready   pair accepted this cycle (equals the pipeline advance term)
//   a_operand  multiplicand, W bits
//   b_operand  multiplier, W bits
//   out_valid  result and flags valid
//   out_ready  downstream accepts the result
//   result     product, W bits
//   Exception  an operand has an all-ones exponent (Inf or NaN)
//   Overflow   rounded exponent above the largest finite exponent
//   Underflow  rounded exponent below 1, result flushed to zero
//
// Latency is STAGES cycles, one result per cycle, and a single global stall:
// every stage advances only when the output register is empty or draining.
module fp_mult_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 3,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_operand,
  input  logic [W-1:0] b_operand,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         Exception,
  output logic         Overflow,
  output logic         Underflow
);

  localparam int PW = 2 * (MAN_W + 1);  // full significand product width
  localparam int XW = EXP_W + 2;        // signed working exponent width
  localparam int NP = STAGES - 1;       // payload registers ahead of the output register

  localparam logic signed [XW-1:0] BIAS    = XW'(2**(EXP_W-1) - 1);
  localparam logic signed [XW-1:0] EXP_TOP = XW'(2**EXP_W - 1);
  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic                 sign;
    logic                 exc;   // an operand is Inf or NaN
    logic                 nan;   // exceptional result is the canonical quiet NaN
    logic                 zero;  // an operand is zero or denormal
    logic signed [XW-1:0] exp;   // ea + eb - bias, before normalisation
    logic [PW-1:0]        prod;  // product of significands with hidden bits
  } stage_t;

  // --------------------------------------------------------------------------
  // Operand decode and significand product
  // --------------------------------------------------------------------------
  logic               a_sign, b_sign;
  logic [EXP_W-1:0]   a_exp,  b_exp;
  logic [MAN_W-1:0]   a_frac, b_frac;
  logic               a_top,  b_top;
  logic               a_zero, b_zero;
  logic               a_nan,  b_nan;
  logic               a_inf,  b_inf;
  stage_t             s_in;

  assign {a_sign, a_exp, a_frac} = a_operand;
  assign {b_sign, b_exp, b_frac} = b_operand;

  assign a_top  = &a_exp;
  assign b_top  = &b_exp;
  assign a_zero = ~|a_exp;
  assign b_zero = ~|b_exp;
  assign a_nan  = a_top &  (|a_frac);
  assign b_nan  = b_top &  (|b_frac);
  assign a_inf  = a_top & ~(|a_frac);
  assign b_inf  = b_top & ~(|b_frac);

  always_comb begin
    s_in      = '0;
    s_in.sign = a_sign ^ b_sign;
    s_in.exc  = a_top | b_top;
    s_in.nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    s_in.zero = a_zero | b_zero;
    s_in.exp  = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;
    s_in.prod = PW'({1'b1, a_frac}) * PW'({1'b1, b_frac});
  end

  // --------------------------------------------------------------------------
  // Payload pipeline. All arithmetic past the product is fused into the final
  // stage, so the intermediate registers are a pure delay line; STAGES only
  // changes the length of that line.
  // --------------------------------------------------------------------------
  logic   adv;
  logic   v_q [NP];
  stage_t p_q [NP];

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NP; i++) begin
        v_q[i] <= 1'b0;
        p_q[i] <= '0;
      end
    end else if (adv) begin
      v_q[0] <= in_valid;
      if (in_valid) p_q[0] <= s_in;
      for (int unsigned i = 1; i < NP; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) p_q[i] <= p_q[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Normalise, round to nearest even, classify
  // --------------------------------------------------------------------------
  stage_t               s_out;
  logic                 norm_sh;
  logic [PW-1:0]        norm;
  logic [MAN_W-1:0]     frac_t;
  logic                 guard, rnd, sticky, rnd_up;
  logic [MAN_W+1:0]     mant;
  logic [MAN_W-1:0]     frac_r;
  logic signed [XW-1:0] exp_r;
  logic [W-1:0]         res_n;
  logic                 exc_n, ovf_n, unf_n;

  assign s_out = p_q[NP-1];

  always_comb begin
    // Product of two [1,2) significands lies in [1,4); after this shift the
    // hidden bit always sits in the MSB.
    norm_sh = s_out.prod[PW-1];
    norm    = norm_sh ? s_out.prod : (s_out.prod << 1);
    frac_t  = norm[PW-2 -: MAN_W];
    guard   = norm[MAN_W];
    rnd     = norm[MAN_W-1];
    sticky  = |norm[MAN_W-2:0];
    rnd_up  = guard & (rnd | sticky | frac_t[0]);

    // A carry out of the rounded significand means it became exactly 2.0.
    mant    = {1'b0, norm[PW-1], frac_t} + (MAN_W+2)'(rnd_up);
    frac_r  = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
    exp_r   = s_out.exp + $signed(XW'(norm_sh)) + $signed(XW'(mant[MAN_W+1]));

    res_n   = {s_out.sign, exp_r[EXP_W-1:0], frac_r};
    exc_n   = 1'b0;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;

    if (s_out.exc) begin
      exc_n = 1'b1;
      res_n = s_out.nan ? QNAN : {s_out.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s_out.zero) begin
      res_n = {s_out.sign, {(W-1){1'b0}}};
    end else if (exp_r >= EXP_TOP) begin
      ovf_n = 1'b1;
      res_n = {s_out.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (exp_r < EXP_ONE) begin
      unf_n = 1'b1;
      res_n = {s_out.sign, {(W-1){1'b0}}};
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      Exception <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else if (adv) begin
      out_valid <= v_q[NP-1];
      if (v_q[NP-1]) begin
        result    <= res_n;
        Exception <= exc_n;
        Overflow  <= ovf_n;
        Underflow <= unf_n;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe -- self-checking bench for fp_mult_pipe (binary32 config).
// Expected {Exception, Overflow, Underflow, result} words are queued when a
// pair is accepted and compared in order when the DUT transfers a result.
module tb_fp_mult_pipe;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int STAGES = 3;
  localparam int W      = 1 + EXP_W + MAN_W;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_operand = '0;
  logic [W-1:0] b_operand = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         Exception, Overflow, Underflow;

  fp_mult_pipe #(
    .EXP_W  (EXP_W),
    .MAN_W  (MAN_W),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .Exception (Exception),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          n_pop  = 0;
  int          n_spur = 0;
  logic [34:0] exp_q [$];
  logic [34:0] obs;
  logic        hold_v = 1'b0;
  logic [34:0] hold_val = '0;

  assign obs = {Exception, Overflow, Underflow, result};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, rounding decided by comparing the
  // discarded remainder against one half ulp.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e, sh;
    logic        s;
    logic [63:0] p, keep, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) begin
      if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
          (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
        return {3'b100, 32'h7FC00000};
      return {3'b100, s, 8'hFF, 23'h0};
    end
    if (ea == 0 || eb == 0) return {3'b000, s, 31'h0};
    p    = {40'h0, 1'b1, a[22:0]} * {40'h0, 1'b1, b[22:0]};
    e    = ea + eb - 127;
    sh   = p[47] ? 24 : 23;
    if (p[47]) e++;
    keep = p >> sh;
    rem  = p & ((64'h1 << sh) - 64'h1);
    half = 64'h1 << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep++;
    if (keep[24]) begin
      keep = keep >> 1;
      e++;
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e < 1)    return {3'b001, s, 31'h0};
    return {3'b000, s, e[7:0], keep[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 3))
      1, 2: begin
        v[30:23] = 8'($urandom_range(90, 164));
        v[22:0]  = v[22:0] & (23'h7FFFFF << $urandom_range(0, 22));
      end
      3: v[30:23] = 8'($urandom_range(1, 254));
      default: ;
    endcase
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic put(input logic [31:0] a, input logic [31:0] b, input logic [34:0] e);
    bit got;
    got       = 1'b0;
    in_valid  = 1'b1;
    a_operand = a;
    b_operand = b;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", in_ready, 1'b1);
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) idle(1);
    chk("drain", exp_q.size(), 0);
  endtask

  // Output monitor: ordering, stall stability, ready behaviour.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (hold_v) chk("stall_hold", {out_valid, obs}, {1'b1, hold_val});
        if (out_valid && exp_q.size() == 0) begin
          n_spur++;
          chk("spurious_out", out_valid, 1'b0);
        end else if (out_valid && out_ready) begin
          chk("result", obs, exp_q.pop_front());
          n_pop++;
        end
        hold_v   = out_valid && !out_ready;
        hold_val = obs;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

  logic [31:0] da [12];
  logic [31:0] db [12];
  logic [34:0] de [12];

  initial begin
    int pop0, spur0;
    logic [31:0] ra, rb;
    bit rand_done;

    da = '{32'h45800000, 32'h40000000, 32'h7F000000, 32'h00800000,
           32'h7F800000, 32'h7F800000, 32'hC1526666, 32'h3FFFFFFF,
           32'h3F800001, 32'h3F800003, 32'h7FC00001, 32'h80400000};
    db = '{32'h45800000, 32'hC0400000, 32'h40000000, 32'h3F000000,
           32'h00000000, 32'hC0000000, 32'h00000000, 32'h3F800001,
           32'h3FC00000, 32'h3FC00000, 32'h3F800000, 32'h3F800000};
    de = '{{3'b000, 32'h4B800000}, {3'b000, 32'hC0C00000},
           {3'b010, 32'h7F800000}, {3'b001, 32'h00000000},
           {3'b100, 32'h7FC00000}, {3'b100, 32'hFF800000},
           {3'b000, 32'h80000000}, {3'b000, 32'h40000000},
           {3'b000, 32'h3FC00002}, {3'b000, 32'h3FC00004},
           {3'b100, 32'h7FC00000}, {3'b000, 32'h80000000}};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {Exception, Overflow, Underflow}, 3'b000);
    #2 rst_n = 1'b1;
    chk("in_ready_after_rst", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Latency of a single pair
    in_valid  = 1'b1;
    a_operand = 32'h45800000;
    b_operand = 32'h45800000;
    @(negedge clk);
    if (in_ready) exp_q.push_back({3'b000, 32'h4B800000});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("latency_0", out_valid, 1'b0);
    for (int i = 1; i < STAGES; i++) begin
      @(posedge clk);
      #1;
      chk((i == STAGES - 1) ? "latency_hit" : "latency_early", out_valid, (i == STAGES - 1));
    end
    drain();

    // Directed vectors, back to back
    for (int i = 0; i < 12; i++) put(da[i], db[i], de[i]);
    drain();

    // Stream of 8 with out_ready pattern 1,0,0 repeating
    pop0 = n_pop;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          ra = rnd_op();
          rb = rnd_op();
          put(ra, rb, model(ra, rb));
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          out_ready = (c % 3 == 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", n_pop - pop0, 8);

    // Reset with two pairs in flight, output stalled
    out_ready = 1'b0;
    put(32'h40000000, 32'h40400000, {3'b000, 32'h40C00000});
    put(32'h3F800000, 32'h3F800000, {3'b000, 32'h3F800000});
    idle(3);
    chk("stalled_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clear_valid", out_valid, 1'b0);
    chk("async_clear_result", result, 32'h0);
    chk("async_clear_flags", {Exception, Overflow, Underflow}, 3'b000);
    exp_q.delete();
    spur0 = n_spur;
    @(posedge clk);
    #3 rst_n = 1'b1;
    chk("in_ready_after_rst2", in_ready, 1'b1);
    out_ready = 1'b1;
    idle(10);
    chk("no_stale", n_spur - spur0, 0);

    // Random pairs against the reference model with random back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 10000; k++) begin
          ra = rnd_op();
          rb = rnd_op();
          put(ra, rb, model(ra, rb));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
